// File: rtl/dmem_ctrl_pkg.sv
// Shared constants and FSM encoding for the vector data-memory arbiter.
package dmem_ctrl_pkg;

  localparam int unsigned DMEM_WORDS = 512;
  localparam int unsigned LINE_WORDS = 16;
  localparam int unsigned WORD_W     = 32;

  localparam int unsigned DEFAULT_ADDR_W = 9;
  localparam int unsigned DEFAULT_DATA_W = LINE_WORDS * WORD_W;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_rr_arbiter.sv
// Two-way round-robin arbiter: a tie goes to the requester not granted last.
module dmem_rr_arbiter
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  input  logic       enable_i,
  output logic [1:0] grant_o,
  output logic       winner_o
);

  always_comb begin
    winner_o = 1'b0;
    unique case (valid_i)
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = ~last_grant_i;
      default: winner_o = 1'b0;
    endcase
  end

  assign grant_o = (enable_i && (|valid_i)) ? (winner_o ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory line port between two valid/ready requesters,
// one transaction in flight, with registered read data.
module dmem_arbiter
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_data_out
);

  dmem_state_e       state_q, state_d;
  logic              last_grant_q;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0]        grant;
  logic              winner;
  logic              accept;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // Ready is masked during reset so nothing is offered while the FSM is unknown.
  dmem_rr_arbiter u_rr_arbiter (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_q),
    .enable_i     ((state_q == StIdle) && reset_n),
    .grant_o      (grant),
    .winner_o     (winner)
  );

  assign accept     = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    cmd_we    = req0_we;
    cmd_addr  = req0_addr;
    cmd_wdata = req0_wdata;
    if (winner) begin
      cmd_we    = req1_we;
      cmd_addr  = req1_addr;
      cmd_wdata = req1_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= winner;
        owner_q      <= winner;
        we_q         <= cmd_we;
        addr_q       <= cmd_addr;
        wdata_q      <= cmd_wdata;
      end
      // Write acks return an all-zero line.
      if (state_q == StAccess) begin
        rdata_q <= we_q ? '0 : mem_data_out;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StAccess;
      end
      StAccess: begin
        mem_re  = ~we_q & reset_n;
        // The memory commits on the falling edge, so reset must block it here.
        mem_we  = we_q & reset_n;
        state_d = StResp;
      end
      StResp: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign rsp0_rdata     = rdata_q;
  assign rsp1_rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 512-word line memory.
module tb_dmem_arbiter;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 512;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          mem_re, mem_we;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data, mem_data_out;

  logic [31:0]   tb_mem  [512];
  logic [31:0]   ref_mem [512];
  bit            mem_init = 1'b0;
  bit            ref_init = 1'b0;

  exp_t          q0[$];
  exp_t          q1[$];
  int            grant_log[$];
  bit            seen0, seen1;
  bit            expect_drop = 1'b0;
  logic [DW-1:0] last_rsp0, last_rsp1;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  dmem_arbiter u_dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req0_valid     (req0_valid),
    .req0_ready     (req0_ready),
    .req0_we        (req0_we),
    .req0_addr      (req0_addr),
    .req0_wdata     (req0_wdata),
    .req1_valid     (req1_valid),
    .req1_ready     (req1_ready),
    .req1_we        (req1_we),
    .req1_addr      (req1_addr),
    .req1_wdata     (req1_wdata),
    .rsp0_valid     (rsp0_valid),
    .rsp0_ready     (rsp0_ready),
    .rsp0_rdata     (rsp0_rdata),
    .rsp1_valid     (rsp1_valid),
    .rsp1_ready     (rsp1_ready),
    .rsp1_rdata     (rsp1_rdata),
    .mem_re         (mem_re),
    .mem_we         (mem_we),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_data_out   (mem_data_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic logic [31:0] init_word(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  function automatic logic [DW-1:0] mk_line(input logic [31:0] base);
    logic [DW-1:0] l;
    for (int i = 0; i < 16; i++) l[511-32*i -: 32] = base + 32'(i);
    return l;
  endfunction

  // Memory model: combinational line read, falling-edge line write, wraps mod 512.
  always_comb begin
    mem_data_out = '0;
    if (mem_re) begin
      for (int i = 0; i < 16; i++) begin
        mem_data_out[511-32*i -: 32] = tb_mem[9'(mem_address + 9'(i))];
      end
    end
  end

  always @(negedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 512; i++) tb_mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (mem_we) begin
      for (int i = 0; i < 16; i++) begin
        tb_mem[9'(mem_address + 9'(i))] <= mem_write_data[511-32*i -: 32];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic accept_cmd(input bit r, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd);
    exp_t e;
    grant_log.push_back(int'(r));
    if (expect_drop) return;
    e.cyc  = cyc;
    e.data = '0;
    for (int i = 0; i < 16; i++) begin
      if (we) ref_mem[9'(a + 9'(i))] = wd[511-32*i -: 32];
      else    e.data[511-32*i -: 32] = ref_mem[9'(a + 9'(i))];
    end
    if (r) q1.push_back(e);
    else   q0.push_back(e);
  endtask

  task automatic chk_rsp(input bit r, input logic v, input logic rdy, input logic [DW-1:0] d);
    exp_t e;
    if (!v) return;
    if ((r ? q1.size() : q0.size()) == 0) begin
      check_eq($sformatf("rsp%0d spurious valid", r), DW'(v), '0);
      return;
    end
    e = r ? q1[0] : q0[0];
    check_eq($sformatf("rsp%0d rdata", r), d, e.data);
    if (!(r ? seen1 : seen0)) begin
      check_eq($sformatf("rsp%0d latency", r), DW'(cyc - e.cyc), DW'(2));
      if (r) seen1 = 1'b1;
      else   seen0 = 1'b1;
    end
    if (rdy) begin
      if (r) begin
        void'(q1.pop_front());
        seen1     = 1'b0;
        last_rsp1 = d;
      end else begin
        void'(q0.pop_front());
        seen0     = 1'b0;
        last_rsp0 = d;
      end
    end
  endtask

  always @(negedge clock) begin
    if (!ref_init) begin
      for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
      ref_init = 1'b1;
    end
    if (req0_valid && req0_ready) accept_cmd(1'b0, req0_we, req0_addr, req0_wdata);
    if (req1_valid && req1_ready) accept_cmd(1'b1, req1_we, req1_addr, req1_wdata);
    chk_rsp(1'b0, rsp0_valid, rsp0_ready, rsp0_rdata);
    chk_rsp(1'b1, rsp1_valid, rsp1_ready, rsp1_rdata);
  end

  task automatic wait_accept(input bit r);
    int n = 0;
    while (n < 50) begin
      @(negedge clock);
      if (r ? req1_ready : req0_ready) break;
      n++;
    end
    check_eq($sformatf("accept%0d", r), DW'(r ? req1_ready : req0_ready), DW'(1));
  endtask

  task automatic issue(input bit r, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    @(posedge clock); #1;
    if (r) begin
      req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = wd;
    end else begin
      req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = wd;
    end
    wait_accept(r);
    @(posedge clock); #1;
    if (r) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_eq("drain", DW'(q0.size() + q1.size()), '0);
  endtask

  initial begin
    int            gl;
    int            n;
    logic [DW-1:0] exp_line;

    reset_n    = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'h000; req0_wdata = '0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'h100; req1_wdata = '0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;

    // Reset held with both requesters asking.
    repeat (3) begin
      @(negedge clock);
      check_eq("reset handshakes",
               DW'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_re, mem_we}), '0);
    end
    check_eq("reset mem_address", DW'(mem_address), '0);
    check_eq("reset mem_write_data", mem_write_data, '0);

    // Tie from reset: grants must alternate starting with requester 0.
    @(posedge clock); #1;
    reset_n = 1'b1;
    n = 0;
    while (grant_log.size() < 4 && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq("tie grant count", DW'(grant_log.size()), DW'(4));
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      check_eq($sformatf("tie grant %0d", i), DW'(grant_log[i]), DW'(i % 2));
    end
    drain();

    // Write then read back through requester 0.
    issue(1'b0, 1'b1, 9'h010, mk_line(32'h0));
    drain();
    issue(1'b0, 1'b0, 9'h010, '0);
    drain();
    check_eq("write-read line", last_rsp0, mk_line(32'h0));

    // Line crossing the top of memory wraps to word 0.
    issue(1'b1, 1'b1, 9'h1F8, mk_line(32'hA0));
    drain();
    issue(1'b1, 1'b0, 9'h000, '0);
    drain();
    check_eq("wrap words 0..7", DW'(last_rsp1[511:256]), DW'(mk_line(32'hA8) >> 256));

    // Stall requester 0's response; requester 1 must wait.
    gl = grant_log.size();
    @(posedge clock); #1;
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'h010;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 9'h100;
    wait_accept(1'b0);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    n = 0;
    while (!rsp0_valid && n < 10) begin
      @(negedge clock);
      n++;
    end
    repeat (5) begin
      @(negedge clock);
      check_eq("stall rsp0_valid", DW'(rsp0_valid), DW'(1));
      check_eq("stall req1_ready", DW'(req1_ready), '0);
    end
    @(posedge clock); #1;
    rsp0_ready = 1'b1;
    wait_accept(1'b1);
    @(posedge clock); #1;
    req1_valid = 1'b0;
    drain();
    check_eq("stall grant first", DW'(grant_log.size() > gl ? grant_log[gl] : -1), '0);
    check_eq("stall grant next", DW'(grant_log.size() > gl + 1 ? grant_log[gl+1] : -1), DW'(1));
    check_eq("stall line", last_rsp0, mk_line(32'h0));

    // Reset during a write's ACCESS cycle: the write must never reach memory.
    @(posedge clock); #1;
    expect_drop = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 9'h080; req0_wdata = mk_line(32'hDEAD0000);
    wait_accept(1'b0);
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(negedge clock);
    check_eq("reset-in-access mem_we", DW'(mem_we), '0);
    @(posedge clock); #1;
    reset_n     = 1'b1;
    req0_valid  = 1'b0;
    expect_drop = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check_eq("dropped write no rsp", DW'({rsp0_valid, rsp1_valid}), '0);
    end
    issue(1'b0, 1'b0, 9'h080, '0);
    drain();
    for (int i = 0; i < 16; i++) exp_line[511-32*i -: 32] = init_word(16'h80 + i);
    check_eq("dropped write old data", last_rsp0, exp_line);

    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
